// File: rtl/i2c_wm8978_wr_pkg.sv
`default_nettype none
//==============================================================================
// Module : i2c_wm8978_wr_pkg
// Brief  : Shared state encoding, phase codes and timing helper for the writer
// Rev    : 1.0
//==============================================================================
package i2c_wm8978_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BYTE  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [6:0] c_wm8978_addr = 7'h1A;

    localparam logic [1:0] c_ph0 = 2'd0;
    localparam logic [1:0] c_ph1 = 2'd1;
    localparam logic [1:0] c_ph2 = 2'd2;
    localparam logic [1:0] c_ph3 = 2'd3;

    // One bit period is four equal phases of this many clk cycles.
    function automatic int unsigned quarter_cycles(input int unsigned clk_freq,
                                                   input int unsigned i2c_freq);
        return clk_freq / (4 * i2c_freq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_wm8978_wr_if.sv
`default_nettype none
//==============================================================================
// Module : i2c_wm8978_wr_if
// Brief  : Command handshake between the config sequencer and the I2C writer
// Rev    : 1.0
//==============================================================================
interface i2c_wm8978_wr_if;
    logic        i2c_exec;
    logic [15:0] i2c_data;
    logic        i2c_done;
    logic        i2c_ack;
    logic        busy;

    modport master (output i2c_exec, i2c_data, input  i2c_done, i2c_ack, busy);
    modport slave  (input  i2c_exec, i2c_data, output i2c_done, i2c_ack, busy);
endinterface
`default_nettype wire

// File: rtl/i2c_wm8978_wr_tick_gen.sv
`default_nettype none
//==============================================================================
// Module : i2c_tick_gen
// Brief  : Quarter-SCL-period tick; restarts from zero when a transfer is accepted
// Rev    : 1.0
//==============================================================================
module i2c_tick_gen
    import i2c_wm8978_wr_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned I2C_FREQ = 250_000
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_restart,
    output logic o_tick
);
    localparam int unsigned c_q = quarter_cycles(CLK_FREQ, I2C_FREQ);
    localparam int unsigned c_w = (c_q > 1) ? $clog2(c_q) : 1;

    generate
        if (c_q < 2) begin : g_bad_cfg
            $error("i2c_tick_gen: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
        end
    endgenerate

    localparam logic [c_w-1:0] c_last = c_w'(c_q - 1);

    logic [c_w-1:0] r_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (i_restart || (r_div == c_last)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_tick = (r_div == c_last);

endmodule
`default_nettype wire

// File: rtl/i2c_wm8978_wr.sv
`default_nettype none
//==============================================================================
// Module : i2c_wm8978_wr
// Brief  : Write-only I2C master sending {reg_addr, reg_data} words to a WM8978
// Rev    : 1.0
//==============================================================================
module i2c_wm8978_wr
    import i2c_wm8978_wr_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned I2C_FREQ   = 250_000,
    parameter logic [6:0]  SLAVE_ADDR = c_wm8978_addr
) (
    input  wire              clk,
    input  wire              rst,
    i2c_wm8978_wr_if.slave   cmd,
    output logic             scl,
    inout  wire              sda
);
    state_t      r_state,    w_state_nxt;
    logic [1:0]  r_phase,    w_phase_nxt;
    logic [2:0]  r_bit_cnt,  w_bit_nxt;
    logic [1:0]  r_byte_cnt, w_byte_nxt;
    logic [15:0] r_data,     w_data_nxt;
    logic [7:0]  r_shift,    w_shift_nxt;
    logic        r_nack,     w_nack_nxt;
    logic        r_scl,      w_scl;
    logic        r_sda_low,  w_sda_low;
    logic        w_accept;
    logic        w_tick;
    wire         w_sda_in = sda;

    i2c_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_accept),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_phase    <= c_ph0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 2'd0;
            r_data     <= 16'd0;
            r_shift    <= 8'd0;
            r_nack     <= 1'b0;
            r_scl      <= 1'b1;
            r_sda_low  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_byte_cnt <= w_byte_nxt;
            r_data     <= w_data_nxt;
            r_shift    <= w_shift_nxt;
            r_nack     <= w_nack_nxt;
            r_scl      <= w_scl;
            r_sda_low  <= w_sda_low;
        end
    end

    // The phase counter wraps 3 -> 0 on its own, so every state just increments it on a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit_cnt;
        w_byte_nxt  = r_byte_cnt;
        w_data_nxt  = r_data;
        w_shift_nxt = r_shift;
        w_nack_nxt  = r_nack;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd.i2c_exec) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_START;
                    w_phase_nxt = c_ph0;
                    w_data_nxt  = cmd.i2c_data;
                    w_nack_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_phase_nxt = r_phase + 2'd1;
                    if (r_phase == c_ph3) begin
                        w_state_nxt = ST_BYTE;
                        w_bit_nxt   = 3'd7;
                        w_byte_nxt  = 2'd0;
                        w_shift_nxt = {SLAVE_ADDR, 1'b0};
                    end
                end
            end
            ST_BYTE: begin
                if (w_tick) begin
                    w_phase_nxt = r_phase + 2'd1;
                    if (r_phase == c_ph3) begin
                        if (r_bit_cnt == 3'd0) begin
                            w_state_nxt = ST_ACK;
                        end else begin
                            w_bit_nxt   = r_bit_cnt - 3'd1;
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end
                    end
                end
            end
            ST_ACK: begin
                if (w_tick) begin
                    w_phase_nxt = r_phase + 2'd1;
                    if ((r_phase == c_ph2) && w_sda_in) begin
                        w_nack_nxt = 1'b1;
                    end
                    if (r_phase == c_ph3) begin
                        if (r_byte_cnt == 2'd2) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_state_nxt = ST_BYTE;
                            w_byte_nxt  = r_byte_cnt + 2'd1;
                            w_bit_nxt   = 3'd7;
                            w_shift_nxt = (r_byte_cnt == 2'd0) ? r_data[15:8] : r_data[7:0];
                        end
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_phase_nxt = r_phase + 2'd1;
                    if (r_phase == c_ph3) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus levels for the current phase; registered so scl/sda come straight from flops.
    always_comb begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        case (r_state)
            ST_START: begin
                w_scl     = (r_phase == c_ph0) || (r_phase == c_ph1);
                w_sda_low = (r_phase != c_ph0);
            end
            ST_BYTE: begin
                w_scl     = (r_phase == c_ph1) || (r_phase == c_ph2);
                w_sda_low = ~r_shift[7];
            end
            ST_ACK: begin
                w_scl     = (r_phase == c_ph1) || (r_phase == c_ph2);
                w_sda_low = 1'b0;
            end
            ST_STOP: begin
                w_scl     = (r_phase != c_ph0);
                w_sda_low = (r_phase == c_ph0) || (r_phase == c_ph1);
            end
            default: begin
                w_scl     = 1'b1;
                w_sda_low = 1'b0;
            end
        endcase
    end

    assign scl          = r_scl;
    assign sda          = r_sda_low ? 1'b0 : 1'bz;
    assign cmd.i2c_done = (r_state == ST_DONE);
    assign cmd.i2c_ack  = r_nack;
    assign cmd.busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_wm8978_wr.sv
`default_nettype none
//==============================================================================
// Module : tb_i2c_wm8978_wr
// Brief  : Directed + random transfers against an I2C slave model with pull-up
// Rev    : 1.0
//==============================================================================
module tb_i2c_wm8978_wr;
    localparam int unsigned c_clk_freq = 50_000_000;
    localparam int unsigned c_i2c_freq = 250_000;
    localparam int          c_q        = c_clk_freq / (4 * c_i2c_freq);
    localparam int          c_done_cyc = 29 * 4 * c_q + 1;
    localparam logic [7:0]  c_dev_wr   = 8'h1A << 1;

    logic clk = 1'b0;
    logic rst;
    wire  scl;
    wire  sda;

    int checks = 0;
    int errors = 0;

    i2c_wm8978_wr_if cmd_if ();

    i2c_wm8978_wr #(
        .CLK_FREQ   (c_clk_freq),
        .I2C_FREQ   (c_i2c_freq),
        .SLAVE_ADDR (7'h1A)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cmd (cmd_if),
        .scl (scl),
        .sda (sda)
    );

    always #10 clk = ~clk;

    // Slave model: pull-up on sda, ACKs each byte unless its bit in nack_mask is set.
    logic       slave_low;
    logic       bfm_clr;
    logic [2:0] nack_mask;
    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    logic       p_scl, p_sda;
    int         bit_n, byte_n, starts, stops;
    logic [7:0] sh;
    logic [7:0] bus_bytes[$];

    always @(negedge clk) begin
        if (bfm_clr) begin
            bit_n     <= 0;
            byte_n    <= 0;
            starts    <= 0;
            stops     <= 0;
            slave_low <= 1'b0;
            bus_bytes.delete();
        end else begin
            if (p_scl && scl && p_sda && !sda) begin
                starts <= starts + 1;
                bit_n  <= 0;
                byte_n <= 0;
            end else if (p_scl && scl && !p_sda && sda) begin
                stops <= stops + 1;
            end
            if (!p_scl && scl) begin
                if (bit_n == 8) begin
                    bit_n  <= 0;
                    byte_n <= byte_n + 1;
                end else begin
                    bit_n <= bit_n + 1;
                    sh    <= {sh[6:0], sda};
                    if (bit_n == 7) bus_bytes.push_back({sh[6:0], sda});
                end
            end
            if (p_scl && !scl) begin
                slave_low <= (bit_n == 8) && !((byte_n < 3) && nack_mask[byte_n]);
            end
        end
        p_scl <= scl;
        p_sda <= sda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a posedge; exec is high for exactly the next sampling edge.
    task automatic launch(input logic [15:0] data, input logic [2:0] mask);
        cmd_if.i2c_data = data;
        nack_mask       = mask;
        cmd_if.i2c_exec = 1'b1;
        bfm_clr         = 1'b1;
        @(posedge clk); #1;
        cmd_if.i2c_exec = 1'b0;
        bfm_clr         = 1'b0;
    endtask

    // Returns the cycle (accept = 0) in which i2c_done is seen; exec pulses at cycles pa/pb.
    task automatic wait_done(input int pa, input int pb, output int n);
        n = 1;
        forever begin
            cmd_if.i2c_exec = (n == pa) || (n == pb);
            if (cmd_if.i2c_done === 1'b1 || n >= 7000) break;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic finish_checks(input string tag, input logic [15:0] data,
                                 input logic [2:0] mask, input int n);
        logic [7:0] exp_b[3];
        exp_b[0] = c_dev_wr;
        exp_b[1] = data[15:8];
        exp_b[2] = data[7:0];
        check({tag, "_done_cycle"}, n, c_done_cyc);
        check({tag, "_ack"}, cmd_if.i2c_ack, (mask != 3'b000) ? 1 : 0);
        check({tag, "_busy_at_done"}, cmd_if.busy, 1);
        check({tag, "_nbytes"}, bus_bytes.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_byte%0d", tag, k),
                  (bus_bytes.size() > k) ? {24'd0, bus_bytes[k]} : 32'hFFFF_FFFF, exp_b[k]);
        end
        check({tag, "_starts"}, starts, 1);
        check({tag, "_stops"}, stops, 1);
        @(posedge clk); #1;
        cmd_if.i2c_exec = 1'b0;
        check({tag, "_done_pulse"}, cmd_if.i2c_done, 0);
        check({tag, "_busy_after"}, cmd_if.busy, 0);
    endtask

    initial begin
        int          n;
        logic [15:0] d;
        logic [2:0]  m;

        rst             = 1'b1;
        bfm_clr         = 1'b1;
        nack_mask       = 3'b000;
        cmd_if.i2c_exec = 1'b0;
        cmd_if.i2c_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl",  scl, 1);
        check("rst_sda",  sda, 1);
        check("rst_done", cmd_if.i2c_done, 0);
        check("rst_ack",  cmd_if.i2c_ack, 0);
        check("rst_busy", cmd_if.busy, 0);
        rst     = 1'b0;
        bfm_clr = 1'b0;
        @(posedge clk); #1;

        launch(16'h0E08, 3'b000);
        wait_done(0, 0, n);
        finish_checks("t1", 16'h0E08, 3'b000, n);

        launch(16'h5A7F, 3'b100);
        wait_done(0, 0, n);
        finish_checks("t2_nack", 16'h5A7F, 3'b100, n);
        launch(16'h1234, 3'b000);
        wait_done(0, 0, n);
        finish_checks("t2_ack", 16'h1234, 3'b000, n);

        // Pulses at 100 (busy) and at the done cycle must be dropped.
        launch(16'h2C1F, 3'b000);
        wait_done(100, c_done_cyc, n);
        finish_checks("t3_first", 16'h2C1F, 3'b000, n);
        launch(16'h3301, 3'b000);
        check("t3_b2b_busy", cmd_if.busy, 1);
        wait_done(0, 0, n);
        finish_checks("t3_second", 16'h3301, 3'b000, n);

        // Reset in mid-transfer after a NACK on the address byte.
        launch(16'h4455, 3'b001);
        n = 1;
        while (n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_ack_before", cmd_if.i2c_ack, 1);
        rst     = 1'b1;
        bfm_clr = 1'b1;
        #1;
        check("t4_scl",  scl, 1);
        check("t4_busy", cmd_if.busy, 0);
        check("t4_ack",  cmd_if.i2c_ack, 0);
        @(negedge clk);
        check("t4_sda",  sda, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t4_no_done", cmd_if.i2c_done, 0);
        end
        rst     = 1'b0;
        bfm_clr = 1'b0;
        @(posedge clk); #1;
        launch(16'h0F1E, 3'b000);
        wait_done(0, 0, n);
        finish_checks("t4_after", 16'h0F1E, 3'b000, n);

        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            m = 3'($urandom_range(0, 7));
            launch(d, m);
            wait_done(0, 0, n);
            finish_checks($sformatf("rnd%0d", i), d, m, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
